// File: rtl/jtframe_ddr_bram_if.sv
// JTFRAME DDR request bus between an initiator (DDR mux side) and a responder.
//
// Handshake: a read or write command is accepted on any rising clk edge where
// ddr_busy is low and ddr_rd or ddr_we is high. A read burst returns
// ddr_burstcnt beats (0 counts as 1), one beat per cycle with ddr_dout_ready high.
// Later write beats are accepted on each edge with ddr_we high. The initiator
// may idle between write beats by dropping ddr_we.
interface jtframe_ddr_bram_if;
    logic        ddr_busy;
    logic [7:0]  ddr_burstcnt;
    logic [28:0] ddr_addr;
    logic        ddr_rd;
    logic        ddr_we;
    logic [7:0]  ddr_be;
    logic [63:0] ddr_din;
    logic [63:0] ddr_dout;
    logic        ddr_dout_ready;

    modport master (
        input  ddr_busy, ddr_dout, ddr_dout_ready,
        output ddr_burstcnt, ddr_addr, ddr_rd, ddr_we, ddr_be, ddr_din
    );

    modport slave (
        output ddr_busy, ddr_dout, ddr_dout_ready,
        input  ddr_burstcnt, ddr_addr, ddr_rd, ddr_we, ddr_be, ddr_din
    );
endinterface

// File: rtl/jtframe_ddr_bram.sv
// Block-RAM responder for the JTFRAME DDR request bus. It serves burst reads
// with a fixed latency of RDLAT and byte-masked burst writes from a 2^AW x 64 memory.
// RDLAT is meant to be 2, 3 or 4. Values above 4 behave as 4.
module jtframe_ddr_bram #(
    parameter int AW    = 10,
    parameter int RDLAT = 2
) (
    input  logic                     rst,
    input  logic                     clk,
    jtframe_ddr_bram_if.slave        ddr,
    output logic [1:0]               o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_WR     = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [63:0]   r_mem [0:(2**AW)-1];

    logic [AW-1:0] r_addr;
    logic [7:0]    r_cnt;
    logic          r_busy;
    logic [63:0]   r_dout;
    logic          r_dout_ready;

    // Extra latency stages beyond the BRAM output register (used when RDLAT > 2)
    logic [63:0]   r_pipe_data [0:1];
    logic [1:0]    r_pipe_vld;
    logic [1:0]    r_pipe_last;

    logic [7:0]    w_cnt_in;
    logic [AW-1:0] w_cmd_addr;
    logic          w_accept_rd;
    logic          w_accept_wr;
    logic          w_wr_beat;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic          w_issue;
    logic          w_issue_last;
    logic [63:0]   w_rd_word;
    logic          w_arr_vld;
    logic          w_arr_last;
    logic [63:0]   w_arr_data;
    logic          w_unused;

    assign w_unused     = ^ddr.ddr_addr[28:AW];
    assign w_cnt_in     = (ddr.ddr_burstcnt == 8'd0) ? 8'd1 : ddr.ddr_burstcnt;
    assign w_cmd_addr   = ddr.ddr_addr[AW-1:0];
    assign w_issue      = (r_state == ST_RD);
    assign w_issue_last = w_issue && (r_cnt == 8'd1);
    assign w_rd_word    = r_mem[r_addr];
    assign w_wr_en      = w_accept_wr | w_wr_beat;
    assign w_wr_addr    = (r_state == ST_IDLE) ? w_cmd_addr : r_addr;

    // Select which point of the latency chain feeds the output register
    always_comb begin
        w_arr_vld  = 1'b0;
        w_arr_last = 1'b0;
        w_arr_data = r_pipe_data[0];
        if (RDLAT <= 2) begin
            w_arr_vld  = w_issue;
            w_arr_last = w_issue_last;
            w_arr_data = w_rd_word;
        end else if (RDLAT == 3) begin
            w_arr_vld  = r_pipe_vld[0];
            w_arr_last = r_pipe_last[0];
            w_arr_data = r_pipe_data[0];
        end else begin
            w_arr_vld  = r_pipe_vld[1];
            w_arr_last = r_pipe_last[1];
            w_arr_data = r_pipe_data[1];
        end
    end

    // Next-state and command decode. In IDLE the busy register is always low,
    // so IDLE alone means a command can be taken. rd has priority over we.
    always_comb begin
        w_next      = r_state;
        w_accept_rd = 1'b0;
        w_accept_wr = 1'b0;
        w_wr_beat   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ddr.ddr_rd) begin
                    w_accept_rd = 1'b1;
                    w_next      = ST_RD;
                end else if (ddr.ddr_we) begin
                    w_accept_wr = 1'b1;
                    if (w_cnt_in != 8'd1) w_next = ST_WR;
                end
            end
            ST_RD: begin
                if (w_issue_last) w_next = w_arr_last ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                if (w_arr_last) w_next = ST_IDLE;
            end
            ST_WR: begin
                if (ddr.ddr_we) begin
                    w_wr_beat = 1'b1;
                    if (r_cnt == 8'd1) w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register. Busy drops on the edge that delivers the final read beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_RD) || (w_next == ST_RDWAIT);
        end
    end

    // Burst address and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= 8'd0;
        end else if (w_accept_rd) begin
            r_addr <= w_cmd_addr;
            r_cnt  <= w_cnt_in;
        end else if (w_accept_wr) begin
            r_addr <= w_cmd_addr + AW'(1);
            r_cnt  <= w_cnt_in - 8'd1;
        end else if (w_issue || w_wr_beat) begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt - 8'd1;
        end
    end

    // Read-beat valid/last flags travelling with the latency stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld  <= 2'b00;
            r_pipe_last <= 2'b00;
        end else begin
            r_pipe_vld  <= {r_pipe_vld[0],  w_issue};
            r_pipe_last <= {r_pipe_last[0], w_issue_last};
        end
    end

    // Latency stage data, not reset
    always_ff @(posedge clk) begin
        if (w_issue) r_pipe_data[0] <= w_rd_word;
        r_pipe_data[1] <= r_pipe_data[0];
    end

    // Output beat register. dout keeps the last beat between bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= 64'd0;
            r_dout_ready <= 1'b0;
        end else begin
            r_dout_ready <= w_arr_vld;
            if (w_arr_vld) r_dout <= w_arr_data;
        end
    end

    // Byte-masked memory write. Masked-off bytes keep their old contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int n = 0; n < 8; n++) begin
                if (ddr.ddr_be[n]) r_mem[w_wr_addr][8*n +: 8] <= ddr.ddr_din[8*n +: 8];
            end
        end
    end

    assign ddr.ddr_busy       = r_busy;
    assign ddr.ddr_dout       = r_dout;
    assign ddr.ddr_dout_ready = r_dout_ready;
    assign o_dbg_state        = r_state;

endmodule
